mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous SRAM between the IF stage (instruction fetch, read-only) and the MEM stage (ld.w/st.w data access).
- Grants at most one request per cycle, with data taking priority over fetch, and an anti-starvation override for fetch.
- Routes each 1-cycle-latency read response back to the requester that was granted.
- Honours the branch cancel from decode so that a squashed fetch never returns data.

Parameters:
- ADDR_W, 32, address width of requesters and SRAM.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive denied fetch cycles after which fetch wins arbitration (range 1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  IF fetch request
- inst_addr  in  ADDR_W  fetch address
- inst_cancel  in  1  branch taken/cancel from decode; squashes fetch
- inst_gnt  out  1  fetch accepted this cycle
- inst_rvalid  out  1  fetch data valid
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  MEM access request
- data_we  in  4  byte write enables; 0 means read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_gnt  out  1  data access accepted this cycle
- data_rvalid  out  1  load data valid
- data_rdata  out  DATA_W  load data
- sram_en  out  1  SRAM enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_en

Behaviour:
- Request qualification (combinational): inst_eff = inst_req & ~inst_cancel & ~reset; data_eff = data_req & ~reset.
- Grant rule: if starve_cnt == STARVE_MAX and inst_eff, grant inst. Otherwise, if data_eff, grant data. Otherwise, if inst_eff, grant inst. At most one grant per cycle.
- The granted request drives sram_en=1, sram_addr and sram_we (0 for inst). sram_wdata = data_wdata when data is granted, else 0. With no grant, all sram_* are 0.
- A requester must hold req/addr/wdata stable until it sees its gnt. A denied request simply retries the next cycle; there is no queueing.
- Pending-response register (owner: NONE/INST/DATA):
  - At the clock edge after a read grant, owner = INST, or DATA only if data_we == 0.
  - A write, or no grant, sets owner = NONE. Stores complete at grant and produce no rvalid.
- Response, cycle N+1 after grant at N:
  - inst_rvalid = (owner == INST) & ~cancel_flag; data_rvalid = (owner == DATA).
  - rdata outputs = sram_rdata when the matching rvalid is set, else 0.
- Cancel handling:
  - inst_cancel in grant cycle N masks the fetch; no grant is issued.
  - inst_cancel in cycle N+1 while owner == INST suppresses inst_rvalid that cycle.
  - cancel_flag is a registered copy of inst_cancel, sampled only when an inst grant occurs at N. If set, the N+1 response is also dropped, so a response is dropped when cancel is seen in either N or N+1.
- Starvation counter (4 bits, saturating at STARVE_MAX):
  - +1 when inst_eff & ~inst_gnt.
  - Cleared on inst_gnt or when ~inst_eff.
  - Reaching STARVE_MAX forces the next inst grant; the counter clears on that grant.
- Back-to-back operation: a new grant may issue in the same cycle a response returns (full throughput, 1 access/cycle).
- Reset (synchronous):
  - owner = NONE, cancel_flag = 0, starve_cnt = 0.
  - All gnt/rvalid/sram_en/sram_we outputs are 0 while reset is high.
  - A response pending at reset is discarded.
- Simultaneous inst_req and data_req with counter below max: data wins and inst is denied (counter +1).

Decomposition:
- Package mem_arb_pkg: owner encoding constants (OWN_NONE=2'd0, OWN_INST=2'd1, OWN_DATA=2'd2) and a default STARVE_MAX constant.
- One sub-module, arb_starve_cnt: the saturating counter with inc/clr inputs and an at_max output.
- Grant logic and the response register stay in the top level.

Test Plan:
- Fetch only: inst_req=1, addr=0x1c000000, SRAM returns 0x02800421 -> inst_gnt at N, inst_rvalid=1 with rdata=0x02800421 at N+1, data_rvalid=0.
- Load vs fetch collision: both req at N, data_addr=0x100, SRAM returns 0xdeadbeef -> data_gnt=1, inst_gnt=0 at N; data_rvalid=1, data_rdata=0xdeadbeef at N+1; inst granted at N+1.
- Store: data_we=4'hf, addr=0x200, wdata=0x12345678 -> sram_we=4'hf, sram_wdata=0x12345678 at N; no rvalid at N+1.
- Starvation: data_req and inst_req held high for 6 cycles, STARVE_MAX=4 -> data granted in cycles 0-3, inst granted in cycle 4, data granted in cycle 5.
- Cancel: inst granted at N, inst_cancel=1 at N+1 -> inst_rvalid=0 at N+1; inst_req with inst_cancel=1 at N -> inst_gnt=0, sram_en=0.
- Reset mid-op: inst read granted at N, reset=1 at N+1 -> inst_rvalid=0 and all outputs 0; normal grant resumes after reset drops.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared types and constants for the memory port arbiter that sits between
// the IF stage, the MEM stage and the single-port synchronous SRAM.
//
// Contents:
//   owner_e        - who owns the read response returning next cycle
//   grant_e        - which requester (if any) wins the SRAM this cycle
//   STARVE_MAX_DEF - default number of denied fetch cycles before fetch
//                    is forced through
//   CNT_W          - width of the starvation counter
//   pick_grant()   - the arbitration priority rule
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_INST = 2'd1,
        GNT_DATA = 2'd2
    } grant_e;

    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 4;

    // Data normally beats fetch, except when fetch has been denied long
    // enough that the starvation counter has reached its ceiling.
    function automatic grant_e pick_grant(input logic starved,
                                          input logic inst_eff,
                                          input logic data_eff);
        grant_e g;
        g = GNT_NONE;
        if (starved && inst_eff) begin
            g = GNT_INST;
        end else if (data_eff) begin
            g = GNT_DATA;
        end else if (inst_eff) begin
            g = GNT_INST;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every bus signal around the arbiter: the fetch port, the data
// port and the SRAM port.
//
//   slave  modport - the arbiter's view (requests in, grants/responses out,
//                    SRAM controls out, SRAM read data in)
//   master modport - the surroundings' view (IF/MEM stages and the SRAM)
//
// Fetch port : inst_req, inst_addr, inst_cancel -> inst_gnt, inst_rvalid,
//              inst_rdata
// Data port  : data_req, data_we, data_addr, data_wdata -> data_gnt,
//              data_rvalid, data_rdata
// SRAM port  : sram_en, sram_we, sram_addr, sram_wdata <- sram_rdata
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_cancel;
    logic              inst_gnt;
    logic              inst_rvalid;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic [3:0]        data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;

    logic              sram_en;
    logic [3:0]        sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr, inst_cancel,
        output inst_gnt, inst_rvalid, inst_rdata,
        input  data_req, data_we, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output inst_req, inst_addr, inst_cancel,
        input  inst_gnt, inst_rvalid, inst_rdata,
        output data_req, data_we, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// ---------------------------------------------------------------------------
// arb_starve_cnt
//
// Saturating counter of consecutive cycles in which a live fetch request
// was denied. Once it sits at STARVE_MAX the arbiter lets fetch through.
//
// Ports:
//   clk     in  clock
//   reset   in  synchronous, active-high reset
//   inc     in  fetch was wanted but not granted this cycle
//   clr     in  fetch was granted, or no fetch is wanted
//   at_max  out counter equals STARVE_MAX
// ---------------------------------------------------------------------------
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; increment stops at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous SRAM between instruction fetch and the
// MEM stage. At most one access is granted per cycle; data has priority
// except when fetch has been starved for STARVE_MAX cycles. Read data comes
// back one cycle after the grant and is steered to whoever was granted.
// A fetch squashed by a branch cancel never returns data.
//
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   bus    mem_port_arbiter_if.slave  fetch, data and SRAM signals
//
// Parameters:
//   ADDR_W      address width (must match the interface)
//   DATA_W      data width (must match the interface)
//   STARVE_MAX  denied fetch cycles before fetch is forced (1..15)
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_port_arbiter_if.slave       bus
);

    logic   inst_eff;
    logic   data_eff;
    logic   starved;
    grant_e grant;

    logic              sram_en_c;
    logic [3:0]        sram_we_c;
    logic [ADDR_W-1:0] sram_addr_c;
    logic [DATA_W-1:0] sram_wdata_c;

    owner_e owner_q;
    owner_e owner_d;
    logic   cancel_flag_q;
    logic   cancel_flag_d;

    logic              inst_rvalid_c;
    logic              data_rvalid_c;

    // A cancelled fetch is treated as no fetch at all, and nothing is
    // requested while reset is high.
    assign inst_eff = bus.inst_req & ~bus.inst_cancel & ~reset;
    assign data_eff = bus.data_req & ~reset;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (inst_eff & (grant != GNT_INST)),
        .clr    ((grant == GNT_INST) | ~inst_eff),
        .at_max (starved)
    );

    assign grant = pick_grant(starved, inst_eff, data_eff);

    // SRAM request mux: the winner owns the SRAM port this cycle; with no
    // winner the whole port is driven to zero.
    always_comb begin
        sram_en_c    = 1'b0;
        sram_we_c    = 4'h0;
        sram_addr_c  = '0;
        sram_wdata_c = '0;
        case (grant)
            GNT_INST: begin
                sram_en_c   = 1'b1;
                sram_addr_c = bus.inst_addr;
            end
            GNT_DATA: begin
                sram_en_c    = 1'b1;
                sram_we_c    = bus.data_we;
                sram_addr_c  = bus.data_addr;
                sram_wdata_c = bus.data_wdata;
            end
            default: begin
            end
        endcase
    end

    assign bus.sram_en    = sram_en_c;
    assign bus.sram_we    = sram_we_c;
    assign bus.sram_addr  = sram_addr_c;
    assign bus.sram_wdata = sram_wdata_c;
    assign bus.inst_gnt   = (grant == GNT_INST);
    assign bus.data_gnt   = (grant == GNT_DATA);

    // Remember who will own next cycle's SRAM read data. Stores complete at
    // grant, so only a data read claims the response. The cancel flag is
    // captured alongside a fetch grant so a late-seen cancel can drop it.
    always_comb begin
        owner_d       = OWN_NONE;
        cancel_flag_d = cancel_flag_q;
        if (grant == GNT_INST) begin
            owner_d       = OWN_INST;
            cancel_flag_d = bus.inst_cancel;
        end else if ((grant == GNT_DATA) && (bus.data_we == 4'h0)) begin
            owner_d = OWN_DATA;
        end
    end

    // Reset drops any response in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q       <= OWN_NONE;
            cancel_flag_q <= 1'b0;
        end else begin
            owner_q       <= owner_d;
            cancel_flag_q <= cancel_flag_d;
        end
    end

    // Response steering. A fetch response is squashed if cancel was seen at
    // grant time (flag) or is asserted now, in the response cycle.
    always_comb begin
        inst_rvalid_c = (owner_q == OWN_INST) & ~cancel_flag_q &
                        ~bus.inst_cancel & ~reset;
        data_rvalid_c = (owner_q == OWN_DATA) & ~reset;
    end

    assign bus.inst_rvalid = inst_rvalid_c;
    assign bus.data_rvalid = data_rvalid_c;
    assign bus.inst_rdata  = inst_rvalid_c ? bus.sram_rdata : '0;
    assign bus.data_rdata  = data_rvalid_c ? bus.sram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed-vector bench for mem_port_arbiter. Each table entry is one clock
// cycle of inputs (including the SRAM read data the bench plays back); some
// entries also carry hand-computed expectations. A transaction-level model
// predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int STARVE = 4;
    localparam int P_NONE = 0;
    localparam int P_INST = 1;
    localparam int P_DATA = 2;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic        icancel;
        logic [31:0] iaddr;
        logic        dreq;
        logic [3:0]  dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] srd;
        bit          lit;
        logic        l_ig;
        logic        l_dg;
        logic        l_irv;
        logic        l_drv;
        logic [31:0] l_rd;
    } vec_t;

    typedef struct {
        logic        ig;
        logic        dg;
        logic        irv;
        logic        drv;
        logic [31:0] ird;
        logic [31:0] drd;
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (STARVE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    // Model state: how long a live fetch has been waiting, and what kind of
    // read response (if any) the previous cycle's grant will return now.
    int fetch_wait = 0;
    int pending    = P_NONE;
    bit pend_cxl   = 0;

    function automatic vec_t mk(logic rst, logic ireq, logic icancel,
                                logic [31:0] iaddr, logic dreq, logic [3:0] dwe,
                                logic [31:0] daddr, logic [31:0] dwdata,
                                logic [31:0] srd);
        vec_t v;
        v.rst = rst; v.ireq = ireq; v.icancel = icancel; v.iaddr = iaddr;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata;
        v.srd = srd;
        v.lit = 0; v.l_ig = 0; v.l_dg = 0; v.l_irv = 0; v.l_drv = 0;
        v.l_rd = 32'h0;
        return v;
    endfunction

    function automatic vec_t pin(vec_t vin, logic ig, logic dg, logic irv,
                                 logic drv, logic [31:0] rd);
        vec_t v;
        v = vin;
        v.lit = 1; v.l_ig = ig; v.l_dg = dg; v.l_irv = irv; v.l_drv = drv;
        v.l_rd = rd;
        return v;
    endfunction

    // Outputs follow from the arbitration rules applied to the model state:
    // starving fetch first, then data, then fetch; the response belongs to
    // last cycle's read winner unless a cancel or reset intervenes.
    function automatic exp_t predict(vec_t v);
        exp_t e;
        bit   want_i;
        bit   want_d;
        int   winner;
        e = '{default: '0};
        if (v.rst) return e;
        want_i = v.ireq && !v.icancel;
        want_d = v.dreq;
        winner = P_NONE;
        if (want_i && fetch_wait >= STARVE) winner = P_INST;
        else if (want_d)                    winner = P_DATA;
        else if (want_i)                    winner = P_INST;
        e.ig = (winner == P_INST);
        e.dg = (winner == P_DATA);
        e.en = (winner != P_NONE);
        if (winner == P_INST) e.addr = v.iaddr;
        if (winner == P_DATA) begin
            e.addr  = v.daddr;
            e.we    = v.dwe;
            e.wdata = v.dwdata;
        end
        e.irv = (pending == P_INST) && !pend_cxl && !v.icancel;
        e.drv = (pending == P_DATA);
        e.ird = e.irv ? v.srd : 32'h0;
        e.drd = e.drv ? v.srd : 32'h0;
        return e;
    endfunction

    task automatic advance_model(vec_t v, exp_t e);
        if (v.rst) begin
            fetch_wait = 0;
            pending    = P_NONE;
            pend_cxl   = 0;
        end else begin
            if (v.ireq && !v.icancel && !e.ig)
                fetch_wait = (fetch_wait + 1 > STARVE) ? STARVE : fetch_wait + 1;
            else
                fetch_wait = 0;
            if (e.ig) begin
                pending  = P_INST;
                pend_cxl = v.icancel;
            end else if (e.dg && v.dwe == 4'h0) begin
                pending = P_DATA;
            end else begin
                pending = P_NONE;
            end
        end
    endtask

    task automatic check_val(int cyc, string name, logic [31:0] got,
                             logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL cycle %0d %s: got %h expected %h",
                     cyc, name, got, want);
        end
    endtask

    task automatic apply_stimulus(vec_t v);
        reset          = v.rst;
        bus.inst_req   = v.ireq;
        bus.inst_cancel= v.icancel;
        bus.inst_addr  = v.iaddr;
        bus.data_req   = v.dreq;
        bus.data_we    = v.dwe;
        bus.data_addr  = v.daddr;
        bus.data_wdata = v.dwdata;
        bus.sram_rdata = v.srd;
    endtask

    task automatic check_output(int cyc, vec_t v, exp_t e);
        check_val(cyc, "inst_gnt",    32'(bus.inst_gnt),    32'(e.ig));
        check_val(cyc, "data_gnt",    32'(bus.data_gnt),    32'(e.dg));
        check_val(cyc, "inst_rvalid", 32'(bus.inst_rvalid), 32'(e.irv));
        check_val(cyc, "inst_rdata",  bus.inst_rdata,       e.ird);
        check_val(cyc, "data_rvalid", 32'(bus.data_rvalid), 32'(e.drv));
        check_val(cyc, "data_rdata",  bus.data_rdata,       e.drd);
        check_val(cyc, "sram_en",     32'(bus.sram_en),     32'(e.en));
        check_val(cyc, "sram_we",     32'(bus.sram_we),     32'(e.we));
        check_val(cyc, "sram_addr",   bus.sram_addr,        e.addr);
        check_val(cyc, "sram_wdata",  bus.sram_wdata,       e.wdata);
        if (v.lit) begin
            check_val(cyc, "lit_inst_gnt",    32'(bus.inst_gnt),    32'(v.l_ig));
            check_val(cyc, "lit_data_gnt",    32'(bus.data_gnt),    32'(v.l_dg));
            check_val(cyc, "lit_inst_rvalid", 32'(bus.inst_rvalid), 32'(v.l_irv));
            check_val(cyc, "lit_data_rvalid", 32'(bus.data_rvalid), 32'(v.l_drv));
            check_val(cyc, "lit_rdata", bus.inst_rdata | bus.data_rdata, v.l_rd);
            check_val(cyc, "model_vs_lit_grant", {30'h0, e.ig, e.dg},
                      {30'h0, v.l_ig, v.l_dg});
            check_val(cyc, "model_vs_lit_rvalid", {30'h0, e.irv, e.drv},
                      {30'h0, v.l_irv, v.l_drv});
        end
    endtask

    task automatic build_vectors();
        // Reset with a live fetch: nothing may be granted.
        vecs.push_back(pin(mk(1,1,0,32'h1c000000,0,4'h0,0,0,0), 0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,4'h0,0,0,0));
        // Fetch only.
        vecs.push_back(pin(mk(0,1,0,32'h1c000000,0,4'h0,0,0,0), 1,0,0,0,0));
        vecs.push_back(pin(mk(0,0,0,0,0,4'h0,0,0,32'h02800421),
                           0,0,1,0,32'h02800421));
        // Load vs fetch collision; fetch gets in the following cycle.
        vecs.push_back(pin(mk(0,1,0,32'h1c000004,1,4'h0,32'h100,0,0), 0,1,0,0,0));
        vecs.push_back(pin(mk(0,1,0,32'h1c000004,0,4'h0,0,0,32'hdeadbeef),
                           1,0,0,1,32'hdeadbeef));
        vecs.push_back(pin(mk(0,0,0,0,0,4'h0,0,0,32'h11111111),
                           0,0,1,0,32'h11111111));
        // Store: no response afterwards.
        vecs.push_back(pin(mk(0,0,0,0,1,4'hf,32'h200,32'h12345678,0), 0,1,0,0,0));
        vecs.push_back(pin(mk(0,0,0,0,0,4'h0,0,0,32'haaaa5555), 0,0,0,0,0));
        // Starvation: both requests held six cycles.
        vecs.push_back(pin(mk(0,1,0,32'h1c000008,1,4'h0,32'h300,0,32'h50000009),
                           0,1,0,0,0));
        vecs.push_back(pin(mk(0,1,0,32'h1c000008,1,4'h0,32'h300,0,32'h5000000a),
                           0,1,0,1,32'h5000000a));
        vecs.push_back(mk(0,1,0,32'h1c000008,1,4'h0,32'h300,0,32'h5000000b));
        vecs.push_back(pin(mk(0,1,0,32'h1c000008,1,4'h0,32'h300,0,32'h5000000c),
                           0,1,0,1,32'h5000000c));
        vecs.push_back(pin(mk(0,1,0,32'h1c000008,1,4'h0,32'h300,0,32'h5000000d),
                           1,0,0,1,32'h5000000d));
        vecs.push_back(pin(mk(0,1,0,32'h1c000008,1,4'h0,32'h300,0,32'h5000000e),
                           0,1,1,0,32'h5000000e));
        vecs.push_back(pin(mk(0,0,0,0,0,4'h0,0,0,32'h5000000f), 0,0,0,1,32'h5000000f));
        // Cancel in the response cycle, then cancel in the grant cycle.
        vecs.push_back(pin(mk(0,1,0,32'h1c000010,0,4'h0,0,0,0), 1,0,0,0,0));
        vecs.push_back(pin(mk(0,0,1,0,0,4'h0,0,0,32'hcafef00d), 0,0,0,0,0));
        vecs.push_back(pin(mk(0,1,1,32'h1c000014,0,4'h0,0,0,0), 0,0,0,0,0));
        vecs.push_back(pin(mk(0,0,0,0,0,4'h0,0,0,32'h77777777), 0,0,0,0,0));
        // Reset while a fetch response is due; fetch resumes after.
        vecs.push_back(pin(mk(0,1,0,32'h1c000020,0,4'h0,0,0,0), 1,0,0,0,0));
        vecs.push_back(pin(mk(1,1,0,32'h1c000024,1,4'h0,32'h400,0,32'h00012345),
                           0,0,0,0,0));
        vecs.push_back(pin(mk(0,1,0,32'h1c000024,0,4'h0,0,0,32'h99999999),
                           1,0,0,0,0));
        vecs.push_back(pin(mk(0,0,0,0,0,4'h0,0,0,32'h55aa55aa), 0,0,1,0,32'h55aa55aa));
        // Partial store followed by a load back to back.
        vecs.push_back(pin(mk(0,0,0,0,1,4'h3,32'h204,32'hbeef0001,0), 0,1,0,0,0));
        vecs.push_back(pin(mk(0,0,0,0,1,4'h0,32'h204,0,32'h13131313), 0,1,0,0,0));
        vecs.push_back(pin(mk(0,0,0,0,0,4'h0,0,0,32'h0000beef), 0,0,0,1,32'h0000beef));
    endtask

    initial begin
        exp_t e;
        build_vectors();
        apply_stimulus(vecs[0]);
        #1;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            e = predict(vecs[i]);
            check_output(i, vecs[i], e);
            @(posedge clk);
            advance_model(vecs[i], e);
            #1;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
